// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and the pipeline controller states.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds an ID source.
// Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     luse
);

  // Destination/source compare for the load in EX
  always_comb begin
    luse = ex_dREN & (ex_wsel != '0) & ((ex_wsel == id_rs) | (ex_wsel == id_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for the 5-stage CPU.
// Optional build macro PIPE_PERF_EN adds stall_cnt / flush_cnt performance counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal issue; hazards resolved by priority each cycle
// MEM_WAIT | dcache access outstanding, whole pipe frozen until dhit
// DRAIN    | halt reached MEM; one cycle to retire it through MEM/WB
// HALTED   | everything frozen, halt flag set until reset
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        mem_halt,
  input  logic        ex_dREN,
  input  regbits_t    ex_wsel,
  input  regbits_t    id_rs,
  input  regbits_t    id_rt,
  input  logic        id_jump,
  input  logic        mem_pcsrc,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        halt
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  pipe_state_t state, nxt;
  logic luse, mem_wait, bubble_q, bubble_now, halt_q;
  logic pc_c, ifid_c, ifid_f, idex_c, idex_f, exmem_c, exmem_f, memwb_c;

  hazard_detect u_hazard (
    .ex_dREN (ex_dREN),
    .ex_wsel (ex_wsel),
    .id_rs   (id_rs),
    .id_rt   (id_rt),
    .luse    (luse)
  );

  assign mem_wait = (mem_dREN | mem_dWEN) & ~dhit;

  // Next-state and per-stage enable/flush decode in priority order
  always_comb begin
    nxt        = state;
    bubble_now = 1'b0;
    pc_c       = 1'b0;
    ifid_c     = 1'b0;
    ifid_f     = 1'b0;
    idex_c     = 1'b0;
    idex_f     = 1'b0;
    exmem_c    = 1'b0;
    exmem_f    = 1'b0;
    memwb_c    = 1'b0;
    case (state)
      HALTED: nxt = HALTED;
      DRAIN: begin
        memwb_c = 1'b1;
        nxt     = HALTED;
      end
      default: begin
        // MEM_WAIT only leaves the frozen condition on dhit, then behaves as RUN
        if (state == RUN || dhit) begin
          nxt = RUN;
          if (mem_wait) begin
            nxt = MEM_WAIT;
          end else if (mem_halt) begin
            ifid_c  = ihit;
            ifid_f  = ihit;
            idex_c  = ihit;
            idex_f  = ihit;
            exmem_c = ihit;
            exmem_f = ihit;
            memwb_c = ihit;
            nxt     = DRAIN;
          end else if (mem_pcsrc & ihit) begin
            pc_c    = 1'b1;
            ifid_c  = 1'b1;
            ifid_f  = 1'b1;
            idex_c  = 1'b1;
            idex_f  = 1'b1;
            exmem_c = 1'b1;
            exmem_f = 1'b1;
            memwb_c = 1'b1;
          end else if (luse & ihit & ~bubble_q) begin
            bubble_now = 1'b1;
            idex_c     = 1'b1;
            idex_f     = 1'b1;
            exmem_c    = 1'b1;
            memwb_c    = 1'b1;
          end else if (id_jump & ihit) begin
            pc_c    = 1'b1;
            ifid_c  = 1'b1;
            ifid_f  = 1'b1;
            idex_c  = 1'b1;
            exmem_c = 1'b1;
            memwb_c = 1'b1;
          end else begin
            pc_c    = ihit;
            ifid_c  = ihit;
            idex_c  = ihit;
            exmem_c = ihit;
            memwb_c = ihit;
          end
        end
      end
    endcase
  end

  // State, one-shot bubble flag and sticky halt flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      bubble_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state    <= nxt;
      bubble_q <= bubble_now;
      if (nxt == HALTED) halt_q <= 1'b1;
    end
  end

  // Outputs forced low while reset is held, independent of the input pins
  always_comb begin
    pc_en       = nRST & pc_c;
    ifid_en     = nRST & ifid_c;
    ifid_flush  = nRST & ifid_f;
    idex_en     = nRST & idex_c;
    idex_flush  = nRST & idex_f;
    exmem_en    = nRST & exmem_c;
    exmem_flush = nRST & exmem_f;
    memwb_en    = nRST & memwb_c;
    halt        = halt_q;
  end

`ifdef PIPE_PERF_EN
  // Free-running, wrapping stall and flush event counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && state != HALTED) stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush | idex_flush | exmem_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: expected output vectors are queued as
// stimulus is applied and popped when the outputs are sampled mid-cycle.
// Vector order: {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb,halt}
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, id_jump, mem_pcsrc;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, exmem_flush, memwb_en, halt;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  localparam logic [8:0] V_ZERO = 9'b000000000;
  localparam logic [8:0] V_RUN  = 9'b110101010;
  localparam logic [8:0] V_BR   = 9'b111111110;
  localparam logic [8:0] V_LU   = 9'b000111010;
  localparam logic [8:0] V_JMP  = 9'b111101010;
  localparam logic [8:0] V_HLT  = 9'b011111110;
  localparam logic [8:0] V_DRN  = 9'b000000010;
  localparam logic [8:0] V_HLTD = 9'b000000001;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .id_jump(id_jump), .mem_pcsrc(mem_pcsrc),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .halt(halt)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  function automatic logic [8:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en, halt};
  endfunction

  task automatic push(input string tag, input logic [8:0] want);
    exp_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    if (exp_q.size() == 0) begin
      chk("sb_empty", outs(), 9'bxxxxxxxxx);
    end else begin
      chk(tag_q.pop_front(), outs(), exp_q.pop_front());
    end
  endtask

  task automatic clr();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
    ex_dREN = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_jump = 1'b0; mem_pcsrc = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] want);
    push(tag, want);
    @(negedge CLK);
    pop_cmp();
  endtask

  task automatic set_luse(input logic [4:0] r);
    ex_dREN = 1'b1; ex_wsel = r; id_rt = r; id_rs = 5'd3;
  endtask

  initial begin
    clr();
    #12;
    expect_out("reset_outs", V_ZERO);
    @(negedge CLK);
    nRST = 1'b1;

    cyc(); clr(); expect_out("run_ihit", V_RUN);
    cyc(); clr(); ihit = 1'b0; expect_out("run_no_ihit", V_ZERO);

    cyc(); clr(); mem_pcsrc = 1'b1; set_luse(5'd8); expect_out("branch_luse", V_BR);
    cyc(); clr(); expect_out("after_branch", V_RUN);

    cyc(); clr(); set_luse(5'd8); expect_out("luse_bubble", V_LU);
    cyc(); clr(); set_luse(5'd8); expect_out("luse_held", V_RUN);
    cyc(); clr(); ex_dREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; expect_out("zero_reg", V_RUN);

    cyc(); clr(); id_jump = 1'b1; expect_out("jump", V_JMP);
    cyc(); clr(); id_jump = 1'b1; set_luse(5'd4); expect_out("jump_luse", V_LU);
    cyc(); clr(); id_jump = 1'b1; expect_out("jump_after", V_JMP);
    cyc(); clr(); id_jump = 1'b1; ihit = 1'b0; expect_out("jump_no_ihit", V_ZERO);

    for (int i = 0; i < 3; i++) begin
      cyc(); clr(); mem_dREN = 1'b1; mem_pcsrc = (i == 1); expect_out("mem_wait", V_ZERO);
    end
    cyc(); clr(); mem_dREN = 1'b1; dhit = 1'b1; expect_out("mem_dhit", V_RUN);
    cyc(); clr(); expect_out("mem_after", V_RUN);
    cyc(); clr(); mem_dWEN = 1'b1; expect_out("store_wait", V_ZERO);
    cyc(); clr(); mem_dWEN = 1'b1; dhit = 1'b1; mem_pcsrc = 1'b1; expect_out("store_dhit_br", V_BR);

    cyc(); clr(); mem_halt = 1'b1; mem_pcsrc = 1'b1; expect_out("halt_flush", V_HLT);
    cyc(); clr(); ihit = 1'b0; expect_out("drain", V_DRN);
    for (int i = 0; i < 10; i++) begin
      cyc(); clr(); expect_out("halted", V_HLTD);
    end

    nRST = 1'b0;
    #1;
    push("reset_from_halted", V_ZERO);
    pop_cmp();
    @(negedge CLK);
    nRST = 1'b1;
    cyc(); clr(); expect_out("run_after_rst", V_RUN);
    cyc(); clr(); mem_halt = 1'b1; expect_out("halt2_flush", V_HLT);
    cyc(); clr(); expect_out("drain2", V_DRN);
    #1;
    nRST = 1'b0;
    #1;
    push("reset_in_drain", V_ZERO);
    pop_cmp();
    @(negedge CLK);
    nRST = 1'b1;
    cyc(); clr(); expect_out("run_after_drain_rst", V_RUN);
    cyc(); clr(); expect_out("run_stays", V_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
